// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C typing,
// independent AW/W buffering and SLVERR/DECERR responses for unmapped accesses.
module axi_lite_regbank #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            REG_COUNT   = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASEADDR    = '0,
    parameter logic [REG_COUNT-1:0]   RO_MASK     = '0,
    parameter logic [REG_COUNT-1:0]   W1C_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                                 CLK,
    input  logic                                 RESETN,
    input  logic [ADDR_WIDTH-1:0]                AWADDR,
    input  logic                                 AWVALID,
    output logic                                 AWREADY,
    input  logic [DATA_WIDTH-1:0]                WDATA,
    input  logic [DATA_WIDTH/8-1:0]              WSTRB,
    input  logic                                 WVALID,
    output logic                                 WREADY,
    output logic [1:0]                           BRESP,
    output logic                                 BVALID,
    input  logic                                 BREADY,
    input  logic [ADDR_WIDTH-1:0]                ARADDR,
    input  logic                                 ARVALID,
    output logic                                 ARREADY,
    output logic [DATA_WIDTH-1:0]                RDATA,
    output logic [1:0]                           RRESP,
    output logic                                 RVALID,
    input  logic                                 RREADY,
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] REG_IN,
    input  logic [REG_COUNT-1:0]                 REG_IN_VALID,
    output logic [REG_COUNT-1:0][DATA_WIDTH-1:0] REG_OUT,
    output logic [REG_COUNT-1:0]                 REG_OUT_VALID
);

    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned LSB     = $clog2(STRB_W);
    localparam int unsigned IDX_W   = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned TAG_LSB = LSB + IDX_W;
    localparam int unsigned IDX_N   = 32'd1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Widen a per-register mask to the full index space so any idx can address it.
    function automatic logic [IDX_N-1:0] ext_mask(input logic [REG_COUNT-1:0] m);
        logic [IDX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) r[i] = m[i];
        return r;
    endfunction

    localparam logic [IDX_N-1:0] IDX_OK = ext_mask('1);
    localparam logic [IDX_N-1:0] RO_EXT = ext_mask(RO_MASK);

    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx = addr[LSB +: IDX_W];
        if ((addr >> TAG_LSB) != (BASEADDR >> TAG_LSB)) return RESP_DECERR;
        if (!IDX_OK[idx])                                return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_nxt;

    logic                  aw_full, w_full, aw_full_nxt, w_full_nxt;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data, strb_mask;
    logic [STRB_W-1:0]     w_strb;
    logic                  commit, wr_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [1:0]            wr_resp;
    logic [REG_COUNT-1:0]  wr_pulse;

    logic                  ar_hs, rvalid_nxt;
    logic [IDX_W-1:0]      rd_idx;
    logic [1:0]            rd_resp;
    logic [DATA_WIDTH-1:0] rd_val;

    assign REG_OUT = regs;

    // Write-side decode: commit waits for both buffers and a free B channel.
    always_comb begin
        commit      = aw_full & w_full & ~BVALID;
        aw_full_nxt = (aw_full & ~commit) | (AWVALID & AWREADY);
        w_full_nxt  = (w_full & ~commit) | (WVALID & WREADY);
        wr_idx      = aw_addr[LSB +: IDX_W];
        wr_resp     = decode_resp(aw_addr);
        if (wr_resp == RESP_OKAY && RO_EXT[wr_idx]) wr_resp = RESP_SLVERR;
        wr_ok = commit & (wr_resp == RESP_OKAY);
        for (int unsigned b = 0; b < STRB_W; b++) strb_mask[8*b +: 8] = {8{w_strb[b]}};
    end

    // Next register contents: AXI write beats hardware load on RW; W1C sets beat clears.
    always_comb begin
        regs_nxt = regs;
        wr_pulse = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            wr_pulse[i] = wr_ok && (wr_idx == IDX_W'(i));
            if (W1C_MASK[i] && !RO_MASK[i]) begin
                regs_nxt[i] = (regs[i] & ~(wr_pulse[i] ? (w_data & strb_mask) : '0))
                            | (REG_IN_VALID[i] ? REG_IN[i] : '0);
            end else if (wr_pulse[i]) begin
                regs_nxt[i] = (regs[i] & ~strb_mask) | (w_data & strb_mask);
            end else if (REG_IN_VALID[i]) begin
                regs_nxt[i] = REG_IN[i];
            end
        end
    end

    // Read-side decode against the current flop contents.
    always_comb begin
        ar_hs      = ARVALID & ARREADY;
        rvalid_nxt = ar_hs | (RVALID & ~RREADY);
        rd_idx     = ARADDR[LSB +: IDX_W];
        rd_resp    = decode_resp(ARADDR);
        rd_val     = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (rd_idx == IDX_W'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) regs <= {REG_COUNT{RESET_VALUE}};
        else         regs <= regs_nxt;
    end

    // Write channel buffers and B response.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            AWREADY       <= 1'b0;
            WREADY        <= 1'b0;
            BVALID        <= 1'b0;
            BRESP         <= RESP_OKAY;
            REG_OUT_VALID <= '0;
        end else begin
            aw_full       <= aw_full_nxt;
            w_full        <= w_full_nxt;
            AWREADY       <= ~aw_full_nxt;
            WREADY        <= ~w_full_nxt;
            REG_OUT_VALID <= wr_pulse;
            if (AWVALID && AWREADY) aw_addr <= AWADDR;
            if (WVALID && WREADY) begin
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) begin
                BVALID <= 1'b1;
                BRESP  <= wr_resp;
            end else if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    // Read channel: one outstanding read, data captured at the AR handshake.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            ARREADY <= ~rvalid_nxt;
            RVALID  <= rvalid_nxt;
            if (ar_hs) begin
                RDATA <= (rd_resp == RESP_OKAY) ? rd_val : '0;
                RRESP <= rd_resp;
            end
        end
    end

endmodule
